// File: rtl/life_pkg.sv
// Shared constants and FSM state encoding for the Game of Life generation sequencer.
package life_pkg;

    localparam int COLS  = 16;
    localparam int ROWS  = 16;
    localparam int CELLS = COLS * ROWS;
    localparam int IDX_W = $clog2(CELLS);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        WAIT_SWAP
    } state_t;

endpackage

// File: rtl/life_cell_rule.sv
// Combinational Conway rule for one cell: gathers the 8 neighbours from a bank and popcounts them.
module life_cell_rule #(
    parameter int COLS  = 16,
    parameter int ROWS  = 16,
    parameter int WRAP  = 0,
    parameter int IDX_W = $clog2(COLS * ROWS)
) (
    input  logic [COLS*ROWS-1:0] bank,
    input  logic [IDX_W-1:0]     idx,
    output logic                 next_cell
);
    import life_pkg::*;

    logic [8:0] nb;
    logic [3:0] n;

    // Neighbour at (row+dr, col+dc); off-grid reads as dead unless the grid is toroidal.
    function automatic logic cell_at(input logic [COLS*ROWS-1:0] b,
                                     input logic [IDX_W-1:0]     i,
                                     input int                   dr,
                                     input int                   dc);
        int r;
        int c;
        r = int'(i) / COLS + dr;
        c = int'(i) % COLS + dc;
        if (WRAP != 0) begin
            r = (r + ROWS) % ROWS;
            c = (c + COLS) % COLS;
        end else if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
            return 1'b0;
        end
        return b[IDX_W'(r * COLS + c)];
    endfunction

    for (genvar gi = 0; gi < 9; gi++) begin : g_nbr
        if (gi == 4) begin : g_self
            assign nb[gi] = 1'b0;
        end else begin : g_cell
            assign nb[gi] = cell_at(bank, idx, gi / 3 - 1, gi % 3 - 1);
        end
    end

    always_comb begin
        n = '0;
        for (int k = 0; k < 9; k++) begin
            n = n + 4'(nb[k]);
        end
    end

    assign next_cell = (n == 4'd3) || (bank[idx] && (n == 4'd2));

endmodule

// File: rtl/life_gen_sequencer.sv
// Double-buffered Life cell store with a serial one-cell-per-clock engine; banks swap only on frame_tick.
module life_gen_sequencer #(
    parameter int COLS       = life_pkg::COLS,
    parameter int ROWS       = life_pkg::ROWS,
    parameter int GEN_PERIOD = 60,
    parameter int WRAP       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_tick,
    input  logic                          run,
    input  logic                          step,
    input  logic                          clear,
    input  logic                          seed_we,
    input  logic [$clog2(COLS*ROWS)-1:0]  seed_addr,
    input  logic                          seed_val,
    input  logic [$clog2(COLS*ROWS)-1:0]  rd_addr,
    output logic                          rd_cell,
    output logic                          busy,
    output logic                          gen_done,
    output logic [15:0]                   generation,
    output logic [$clog2(COLS*ROWS):0]    alive_count
);
    import life_pkg::*;

    localparam int N_CELLS = COLS * ROWS;
    localparam int AW      = $clog2(N_CELLS);
    localparam int FC_W    = $clog2(GEN_PERIOD + 1);

    state_t                     state_reg, state_next;
    logic [1:0][N_CELLS-1:0]    bank_reg;
    logic                       front_sel_reg;
    logic [FC_W-1:0]            frame_cnt_reg;
    logic [AW-1:0]              idx_reg;
    logic [AW:0]                acc_reg;
    logic                       rd_cell_reg;
    logic                       gen_done_reg;
    logic [15:0]                generation_reg;
    logic [AW:0]                alive_count_reg;

    logic [N_CELLS-1:0]         front_bank;
    logic                       next_cell;
    logic                       start;
    logic                       swap;
    logic                       seed_ok;
    logic                       rd_ok;

    assign front_bank = front_sel_reg ? bank_reg[1] : bank_reg[0];

    // Only a non-power-of-two grid can see indices past the last cell.
    if (N_CELLS == (1 << AW)) begin : g_full
        assign seed_ok = 1'b1;
        assign rd_ok   = 1'b1;
    end else begin : g_part
        assign seed_ok = (seed_addr < AW'(N_CELLS));
        assign rd_ok   = (rd_addr < AW'(N_CELLS));
    end

    life_cell_rule #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .WRAP  (WRAP),
        .IDX_W (AW)
    ) u_rule (
        .bank      (front_bank),
        .idx       (idx_reg),
        .next_cell (next_cell)
    );

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        swap       = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((run && frame_cnt_reg == FC_W'(GEN_PERIOD)) || (!run && step)) begin
                    start      = 1'b1;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (idx_reg == AW'(N_CELLS - 1)) begin
                    state_next = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (frame_tick) begin
                    swap       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            bank_reg        <= '0;
            front_sel_reg   <= 1'b0;
            frame_cnt_reg   <= '0;
            idx_reg         <= '0;
            acc_reg         <= '0;
            rd_cell_reg     <= 1'b0;
            gen_done_reg    <= 1'b0;
            generation_reg  <= '0;
            alive_count_reg <= '0;
        end else begin
            state_reg <= state_next;

            // The swap tick still counts, so a running period is exactly GEN_PERIOD frames.
            if (start) begin
                frame_cnt_reg <= '0;
            end else if (frame_tick && run && (int'(frame_cnt_reg) < GEN_PERIOD)) begin
                frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
            end

            if (start) begin
                idx_reg <= '0;
                acc_reg <= '0;
            end else if (state_reg == COMPUTE) begin
                idx_reg <= idx_reg + AW'(1);
                acc_reg <= acc_reg + (AW+1)'(next_cell);
            end

            if (state_reg == IDLE) begin
                if (clear) begin
                    bank_reg[front_sel_reg] <= '0;
                end else if (seed_we && seed_ok) begin
                    bank_reg[front_sel_reg][seed_addr] <= seed_val;
                end
            end else if (state_reg == COMPUTE) begin
                bank_reg[~front_sel_reg][idx_reg] <= next_cell;
            end

            gen_done_reg <= swap;
            if (swap) begin
                front_sel_reg   <= ~front_sel_reg;
                generation_reg  <= generation_reg + 16'd1;
                alive_count_reg <= acc_reg;
            end else if (state_reg == IDLE && clear) begin
                alive_count_reg <= '0;
            end

            rd_cell_reg <= rd_ok & front_bank[rd_addr];
        end
    end

    assign rd_cell     = rd_cell_reg;
    assign busy        = (state_reg != IDLE);
    assign gen_done    = gen_done_reg;
    assign generation  = generation_reg;
    assign alive_count = alive_count_reg;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Randomized bench: two instances (flat and toroidal) share stimulus and are compared to a grid-level Life model.
module tb_life_gen_sequencer;

    localparam int COLS  = 16;
    localparam int ROWS  = 16;
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = 8;
    localparam int GP    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0;
    logic run = 1'b0;
    logic step = 1'b0;
    logic clear = 1'b0;
    logic seed_we = 1'b0;
    logic seed_val = 1'b0;
    logic [AW-1:0] seed_addr = '0;
    logic [AW-1:0] rd_addr = '0;

    logic [1:0]         rd_cell;
    logic [1:0]         busy;
    logic [1:0]         gen_done;
    logic [1:0][15:0]   generation;
    logic [1:0][AW:0]   alive_count;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        life_gen_sequencer #(
            .COLS       (COLS),
            .ROWS       (ROWS),
            .GEN_PERIOD (GP),
            .WRAP       (gi)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .frame_tick  (frame_tick),
            .run         (run),
            .step        (step),
            .clear       (clear),
            .seed_we     (seed_we),
            .seed_addr   (seed_addr),
            .seed_val    (seed_val),
            .rd_addr     (rd_addr),
            .rd_cell     (rd_cell[gi]),
            .busy        (busy[gi]),
            .gen_done    (gen_done[gi]),
            .generation  (generation[gi]),
            .alive_count (alive_count[gi])
        );
    end

    always #5 clk = ~clk;

    // Reference: displayed grid per instance (0 = flat edges, 1 = torus).
    bit grid [2][ROWS][COLS];
    int m_gen;
    int m_alive [2];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int live_at(input int w, input int r, input int c);
        if (w == 1) begin
            return int'(grid[w][(r + ROWS) % ROWS][(c + COLS) % COLS]);
        end
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 0;
        return int'(grid[w][r][c]);
    endfunction

    task automatic model_gen();
        bit nxt [ROWS][COLS];
        for (int w = 0; w < 2; w++) begin
            m_alive[w] = 0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    int n = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            if (dr != 0 || dc != 0) n += live_at(w, r + dr, c + dc);
                    nxt[r][c] = (n == 3) || (grid[w][r][c] && n == 2);
                end
            end
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    grid[w][r][c] = nxt[r][c];
                    m_alive[w] += int'(nxt[r][c]);
                end
        end
        m_gen = (m_gen + 1) % 65536;
    endtask

    task automatic model_clear();
        for (int w = 0; w < 2; w++) begin
            m_alive[w] = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) grid[w][r][c] = 1'b0;
        end
    endtask

    task automatic seed(input int a, input bit v);
        seed_we = 1'b1; seed_addr = AW'(a); seed_val = v;
        cyc();
        seed_we = 1'b0;
        for (int w = 0; w < 2; w++) grid[w][a / COLS][a % COLS] = v;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        model_clear();
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < CELLS; a++) begin
            rd_addr = AW'(a);
            cyc();
            for (int w = 0; w < 2; w++)
                check($sformatf("%s w%0d cell%0d", tag, w, a), int'(rd_cell[w]), int'(grid[w][a / COLS][a % COLS]));
        end
    endtask

    task automatic check_status(input string tag, input int exp_busy, input int exp_done);
        for (int w = 0; w < 2; w++) begin
            check($sformatf("%s w%0d busy", tag, w), int'(busy[w]), exp_busy);
            check($sformatf("%s w%0d gen_done", tag, w), int'(gen_done[w]), exp_done);
            check($sformatf("%s w%0d generation", tag, w), int'(generation[w]), m_gen);
            check($sformatf("%s w%0d alive", tag, w), int'(alive_count[w]), m_alive[w]);
        end
    endtask

    // One single-stepped generation with ignored writes while busy and an early tick that must not swap.
    task automatic do_gen(input string tag, input bit with_seed);
        int a;
        step = 1'b1;
        if (with_seed) begin
            a = $urandom_range(0, CELLS - 1);
            seed_we = 1'b1; seed_addr = AW'(a); seed_val = 1'($urandom_range(0, 1));
            for (int w = 0; w < 2; w++) grid[w][a / COLS][a % COLS] = seed_val;
        end
        cyc();
        step = 1'b0; seed_we = 1'b0;
        for (int w = 0; w < 2; w++) check($sformatf("%s start w%0d busy", tag, w), int'(busy[w]), 1);
        a = $urandom_range(0, CELLS - 1);
        seed_we = 1'b1; seed_addr = AW'(a); seed_val = ~grid[0][a / COLS][a % COLS];
        cyc();
        seed_we = 1'b0; clear = 1'b1;
        cyc();
        clear = 1'b0; step = 1'b1;
        cyc();
        step = 1'b0;
        repeat (252) cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check_status({tag, " early tick"}, 1, 0);
        read_all({tag, " hold"});
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        model_gen();
        check_status({tag, " swap"}, 0, 1);
        cyc();
        check_status({tag, " after"}, 0, 0);
        read_all({tag, " new"});
    endtask

    initial begin
        int a;
        bit exp_done;
        m_gen = 0;
        model_clear();

        // Reset from power-up, then again from a random pre-state.
        rst_n = 1'b0;
        cyc(); cyc();
        check_status("por", 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) seed($urandom_range(0, CELLS - 1), 1'($urandom_range(0, 1)));
        step = 1'b1;
        cyc();
        step = 1'b0;
        repeat (20) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        model_clear(); m_gen = 0;
        check_status("rst", 0, 0);
        read_all("rst");

        // Blinker
        seed(17, 1); seed(18, 1); seed(19, 1);
        do_gen("blinker", 1'b0);
        check("blinker alive const", int'(alive_count[0]), 3);

        // Seed and clear together: clear wins
        seed_we = 1'b1; seed_addr = AW'(5); seed_val = 1'b1; clear = 1'b1;
        cyc();
        seed_we = 1'b0; clear = 1'b0;
        model_clear();
        rd_addr = AW'(5);
        cyc();
        check("collision cell5", int'(rd_cell[0]), 0);
        check("collision alive", int'(alive_count[0]), 0);

        // Block still life
        seed(0, 1); seed(1, 1); seed(16, 1); seed(17, 1);
        do_gen("block", 1'b0);

        // Corners: die with flat edges, form a block on the torus
        do_clear();
        seed(0, 1); seed(15, 1); seed(240, 1); seed(255, 1);
        do_gen("corners", 1'b0);
        check("corners flat alive", int'(alive_count[0]), 0);
        check("corners torus alive", int'(alive_count[1]), 4);

        // Random soups, one or two generations each
        for (int rnd = 0; rnd < 4; rnd++) begin
            do_clear();
            repeat ($urandom_range(20, 80)) seed($urandom_range(0, CELLS - 1), 1'($urandom_range(0, 3) != 0));
            do_gen($sformatf("rand%0d", rnd), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) do_gen($sformatf("rand%0d b", rnd), 1'b1);
        end

        // Reset part-way through COMPUTE
        step = 1'b1;
        cyc();
        step = 1'b0;
        repeat (100) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        model_clear(); m_gen = 0;
        check_status("midrst", 0, 0);
        for (int w = 0; w < 2; w++) check($sformatf("midrst w%0d rd_cell", w), int'(rd_cell[w]), 0);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check_status("midrst tick", 0, 0);
        read_all("midrst");

        // Free-running pacing: generations land on ticks P+1, 2P+1, 3P+1
        seed(17, 1); seed(18, 1); seed(19, 1);
        run = 1'b1;
        for (int t = 1; t <= 13; t++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            exp_done = (t == GP + 1) || (t == 2 * GP + 1) || (t == 3 * GP + 1);
            if (exp_done) model_gen();
            check_status($sformatf("pace t%0d", t), 0, int'(exp_done));
            for (int k = 1; k <= 300; k++) begin
                if (k == 11 && (t % GP) == 0) begin
                    a = $urandom_range(0, CELLS - 1);
                    seed_we = 1'b1; seed_addr = AW'(a); seed_val = ~grid[0][a / COLS][a % COLS];
                    step = 1'b1;
                end
                if (k == 11 && t == 2) step = 1'b1;
                if (k == 12) begin
                    seed_we = 1'b0; step = 1'b0;
                end
                if (k == 20 && t == 3 * GP) run = 1'b0;
                cyc();
                if (k == 10)
                    for (int w = 0; w < 2; w++)
                        check($sformatf("pace t%0d w%0d busy", t, w), int'(busy[w]), int'((t % GP) == 0));
                if (k == 12 && t == 2)
                    for (int w = 0; w < 2; w++)
                        check($sformatf("pace step-while-run w%0d busy", w), int'(busy[w]), 0);
            end
        end
        read_all("pace");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
